// File: rtl/memory_arbiter_pkg.sv
// memory_arbiter_pkg: state/owner encodings shared by the memory arbiter.
// Optional fairness is enabled with MEMORY_ARBITER_FAIRNESS_EN.
package memory_arbiter_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_ISSUE = 2'd1,
    ARB_WAIT  = 2'd2
  } arb_state_t;

  typedef enum logic {
    ARB_OWN_I = 1'b0,
    ARB_OWN_D = 1'b1
  } arb_own_t;

  // Bits needed to hold the values 0..n-1.
  function automatic int unsigned cnt_w(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/memory_arbiter_timer.sv
// memory_arbiter_timer: clear/enable counter that flags its final count.
// Holds at TIMEOUT_CYC-1 until cleared.
module memory_arbiter_timer
  import memory_arbiter_pkg::*;
#(
  parameter int TIMEOUT_CYC = 64
) (
  input  logic clock,
  input  logic reset_n,
  input  logic clear,
  input  logic enable,
  output logic expire
);

  localparam int unsigned CW = cnt_w(TIMEOUT_CYC);
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYC - 1);

  logic [CW-1:0] count;

  assign expire = enable && (count == LAST);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable && !expire) begin
      count <= count + CW'(1);
    end
  end

endmodule

// File: rtl/memory_arbiter.sv
// memory_arbiter: serialises l1i reads and l1d reads/writes onto one port.
// Define MEMORY_ARBITER_FAIRNESS_EN to bound d-side streaks while i waits.
module memory_arbiter
  import memory_arbiter_pkg::*;
#(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int TIMEOUT_CYC  = 64,
  parameter int MAX_D_STREAK = 4
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_address,
  output logic              i_done,
  output logic [DATA_W-1:0] i_rdata,
  output logic              i_stall,
  input  logic              d_req,
  input  logic              d_write,
  input  logic [ADDR_W-1:0] d_address,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_done,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_stall,
  output logic              m_req,
  output logic              m_write,
  output logic [ADDR_W-1:0] m_address,
  output logic [DATA_W-1:0] m_wdata,
  input  logic              m_accept,
  input  logic              m_valid,
  input  logic [DATA_W-1:0] m_rdata,
  output logic              err
);

  if (TIMEOUT_CYC < 2 || MAX_D_STREAK < 1) begin : g_bad_cfg
    $error("memory_arbiter: bad parameters");
  end

  arb_state_t  state;
  arb_state_t  state_nx;
  arb_own_t    owner;
  logic        force_i;
  logic        grant_i;
  logic        grant_d;
  logic        wr_fin;
  logic        rd_fin;
  logic        fin;
  logic        timed_out;
  logic        expire;
  logic [DATA_W-1:0] rd_data;

  assign i_stall = i_req && !i_done;
  assign d_stall = d_req && !d_done;
  assign m_req   = (state == ARB_ISSUE);

`ifdef MEMORY_ARBITER_FAIRNESS_EN
  localparam int unsigned SW = cnt_w(MAX_D_STREAK + 1);
  localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_D_STREAK);

  logic [SW-1:0] streak;

  assign force_i = i_req && (streak == STREAK_MAX);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      streak <= '0;
    end else if (grant_i) begin
      streak <= '0;
    end else if (grant_d && i_req && streak != STREAK_MAX) begin
      streak <= streak + SW'(1);
    end
  end
`else
  assign force_i = 1'b0;
`endif

  memory_arbiter_timer #(
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) u_timer (
    .clock  (clock),
    .reset_n(reset_n),
    .clear  (state == ARB_ISSUE),
    .enable (state == ARB_WAIT),
    .expire (expire)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state <= ARB_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      ARB_IDLE: begin
        if (grant_i || grant_d) state_nx = ARB_ISSUE;
      end
      ARB_ISSUE: begin
        if (m_accept) state_nx = m_write ? ARB_IDLE : ARB_WAIT;
      end
      ARB_WAIT: begin
        if (m_valid || expire) state_nx = ARB_IDLE;
      end
      default: state_nx = ARB_IDLE;
    endcase
  end

  // A done cycle never grants, giving the one-cycle gap between transactions.
  always_comb begin
    grant_d   = 1'b0;
    grant_i   = 1'b0;
    wr_fin    = 1'b0;
    rd_fin    = 1'b0;
    timed_out = 1'b0;
    rd_data   = '0;
    if (state == ARB_IDLE && !i_done && !d_done) begin
      grant_d = d_req && !force_i;
      grant_i = i_req && !grant_d;
    end
    wr_fin    = (state == ARB_ISSUE) && m_accept && m_write;
    rd_fin    = (state == ARB_WAIT) && (m_valid || expire);
    timed_out = (state == ARB_WAIT) && !m_valid && expire;
    if (m_valid) rd_data = m_rdata;
  end

  assign fin = wr_fin || rd_fin;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      owner     <= ARB_OWN_I;
      m_write   <= 1'b0;
      m_address <= '0;
      m_wdata   <= '0;
      i_done    <= 1'b0;
      d_done    <= 1'b0;
      i_rdata   <= '0;
      d_rdata   <= '0;
      err       <= 1'b0;
    end else begin
      i_done <= fin && (owner == ARB_OWN_I);
      d_done <= fin && (owner == ARB_OWN_D);
      if (timed_out) err <= 1'b1;
      if (grant_d) begin
        owner     <= ARB_OWN_D;
        m_write   <= d_write;
        m_address <= d_address;
        m_wdata   <= d_wdata;
      end else if (grant_i) begin
        owner     <= ARB_OWN_I;
        m_write   <= 1'b0;
        m_address <= i_address;
        m_wdata   <= '0;
      end
      if (rd_fin && owner == ARB_OWN_I) i_rdata <= rd_data;
      if (rd_fin && owner == ARB_OWN_D) d_rdata <= rd_data;
    end
  end

endmodule

// File: tb/tb_memory_arbiter.sv
// tb_memory_arbiter: vector table, directed corner cases and a randomized
// run against a transaction-level memory model.
module tb_memory_arbiter;

  localparam int TO = 16;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        i_req = 1'b0;
  logic [31:0] i_address = '0;
  logic        i_done;
  logic [31:0] i_rdata;
  logic        i_stall;
  logic        d_req = 1'b0;
  logic        d_write = 1'b0;
  logic [31:0] d_address = '0;
  logic [31:0] d_wdata = '0;
  logic        d_done;
  logic [31:0] d_rdata;
  logic        d_stall;
  logic        m_req;
  logic        m_write;
  logic [31:0] m_address;
  logic [31:0] m_wdata;
  logic        m_accept = 1'b0;
  logic        m_valid = 1'b0;
  logic [31:0] m_rdata = '0;
  logic        err;

  memory_arbiter #(
    .ADDR_W(32),
    .DATA_W(32),
    .TIMEOUT_CYC(TO),
    .MAX_D_STREAK(4)
  ) dut (
    .clock(clock), .reset_n(reset_n),
    .i_req(i_req), .i_address(i_address),
    .i_done(i_done), .i_rdata(i_rdata), .i_stall(i_stall),
    .d_req(d_req), .d_write(d_write), .d_address(d_address),
    .d_wdata(d_wdata), .d_done(d_done), .d_rdata(d_rdata),
    .d_stall(d_stall),
    .m_req(m_req), .m_write(m_write), .m_address(m_address),
    .m_wdata(m_wdata), .m_accept(m_accept), .m_valid(m_valid),
    .m_rdata(m_rdata), .err(err)
  );

  always #5 clock = ~clock;

  int total = 0;
  int bad = 0;
  bit mon = 1'b0;
  bit rstop = 1'b0;
  logic [31:0] mem [logic [31:0]];

  typedef struct {
    logic ir; logic [31:0] ia;
    logic dr; logic dw; logic [31:0] da; logic [31:0] dd;
    logic ma; logic mv; logic [31:0] md;
    logic xmr; logic xmw; logic [31:0] xma; logic [31:0] xmd;
    logic xid; logic xdd; logic [31:0] xir; logic [31:0] xdr;
    logic xis; logic xds;
  } vec_t;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  function automatic logic [31:0] minit(input logic [31:0] a);
    return a * 32'h9E37_79B9 + 32'h0123_4567;
  endfunction

  task automatic zero_in();
    i_req = 0; i_address = '0; d_req = 0; d_write = 0;
    d_address = '0; d_wdata = '0;
    m_accept = 0; m_valid = 0; m_rdata = '0;
  endtask

  task automatic wait_mreq(input string nm);
    int n = 0;
    while (!m_req && n < 20) begin step(); n++; end
    chk(nm, m_req, 1);
  endtask

  task automatic rd_txn(input bit d, input logic [31:0] a,
                        input logic [31:0] data, input string nm);
    if (d) begin
      d_req = 1; d_write = 0; d_address = a;
    end else begin
      i_req = 1; i_address = a;
    end
    wait_mreq({nm, "_mreq"});
    chk({nm, "_addr"}, m_address, a);
    m_accept = 1; step(); m_accept = 0;
    m_valid = 1; m_rdata = data; step(); m_valid = 0;
    chk({nm, "_done"}, d ? d_done : i_done, 1);
    chk({nm, "_data"}, d ? d_rdata : i_rdata, data);
    d_req = 0; i_req = 0;
    step();
  endtask

  always @(negedge clock) begin
    if (mon) begin
      chk("mon_i_stall", i_stall, i_req && !i_done);
      chk("mon_d_stall", d_stall, d_req && !d_done);
    end
  end

  task automatic i_thread();
    logic [31:0] a;
    int n;
    repeat (30) begin
      repeat ($urandom_range(0, 3)) step();
      a = 32'h1000 + ($urandom_range(0, 15) << 2);
      i_req = 1; i_address = a;
      n = 0;
      do begin step(); n++; end while (!i_done && n < 300);
      chk("rand_i_done", i_done, 1);
      chk("rand_i_rdata", i_rdata, minit(a));
      i_req = 0;
    end
  endtask

  task automatic d_thread();
    logic [31:0] shadow [8];
    logic [31:0] a;
    logic [31:0] wd;
    int idx;
    bit w;
    int n;
    for (int k = 0; k < 8; k++) shadow[k] = minit(32'h2000 + k * 4);
    repeat (40) begin
      repeat ($urandom_range(0, 3)) step();
      idx = $urandom_range(0, 7);
      a = 32'h2000 + idx * 4;
      w = 1'($urandom_range(0, 1));
      wd = $urandom();
      d_req = 1; d_write = w; d_address = a; d_wdata = wd;
      n = 0;
      do begin step(); n++; end while (!d_done && n < 300);
      chk("rand_d_done", d_done, 1);
      if (w) shadow[idx] = wd;
      else chk("rand_d_rdata", d_rdata, shadow[idx]);
      d_req = 0;
    end
  endtask

  task automatic responder();
    logic [31:0] a;
    logic [31:0] wd;
    logic w;
    while (!rstop) begin
      if (m_req) begin
        repeat ($urandom_range(0, 3)) step();
        a = m_address; w = m_write; wd = m_wdata;
        m_accept = 1; step(); m_accept = 0;
        if (w) begin
          mem[a] = wd;
        end else begin
          repeat ($urandom_range(0, TO - 3)) step();
          m_valid = 1;
          m_rdata = mem.exists(a) ? mem[a] : minit(a);
          step();
          m_valid = 0;
        end
      end else begin
        m_valid = ($urandom_range(0, 7) == 0);
        m_rdata = $urandom();
        step();
        m_valid = 0;
      end
    end
  endtask

  vec_t v [13];

  initial begin
    int n;
    int dcnt;
    int igr;
    logic e_prev;

    v[0]  = '{1,32'h100, 0,0,0,0, 0,0,0,
              0,0,0,0, 0,0,0,0, 1,0};
    v[1]  = '{1,32'h100, 0,0,0,0, 1,0,0,
              1,0,32'h100,0, 0,0,0,0, 1,0};
    v[2]  = '{1,32'h100, 0,0,0,0, 0,0,0,
              0,0,32'h100,0, 0,0,0,0, 1,0};
    v[3]  = '{1,32'h100, 0,0,0,0, 0,1,32'hDEADBEEF,
              0,0,32'h100,0, 0,0,0,0, 1,0};
    v[4]  = '{1,32'h100, 0,0,0,0, 0,0,0,
              0,0,32'h100,0, 1,0,32'hDEADBEEF,0, 0,0};
    v[5]  = '{0,0, 0,0,0,0, 0,1,32'h77,
              0,0,32'h100,0, 0,0,32'hDEADBEEF,0, 0,0};
    v[6]  = '{0,0, 0,0,0,0, 0,0,0,
              0,0,32'h100,0, 0,0,32'hDEADBEEF,0, 0,0};
    v[7]  = '{0,0, 1,1,32'h40,32'h55AA, 0,0,0,
              0,0,32'h100,0, 0,0,32'hDEADBEEF,0, 0,1};
    v[8]  = '{0,0, 1,1,32'h40,32'h55AA, 0,0,0,
              1,1,32'h40,32'h55AA, 0,0,32'hDEADBEEF,0, 0,1};
    v[9]  = '{0,0, 1,1,32'h999,32'hFFFF, 0,0,0,
              1,1,32'h40,32'h55AA, 0,0,32'hDEADBEEF,0, 0,1};
    v[10] = '{0,0, 1,1,32'h999,32'hFFFF, 1,0,0,
              1,1,32'h40,32'h55AA, 0,0,32'hDEADBEEF,0, 0,1};
    v[11] = '{0,0, 1,0,32'h999,32'hFFFF, 0,0,0,
              0,1,32'h40,32'h55AA, 0,1,32'hDEADBEEF,0, 0,0};
    v[12] = '{0,0, 0,0,0,0, 0,0,0,
              0,1,32'h40,32'h55AA, 0,0,32'hDEADBEEF,0, 0,0};

    // reset state
    zero_in();
    reset_n = 0;
    repeat (2) @(posedge clock);
    #1;
    chk("rst_m_req", m_req, 0);
    chk("rst_m_write", m_write, 0);
    chk("rst_m_address", m_address, 0);
    chk("rst_m_wdata", m_wdata, 0);
    chk("rst_i_done", i_done, 0);
    chk("rst_d_done", d_done, 0);
    chk("rst_i_rdata", i_rdata, 0);
    chk("rst_d_rdata", d_rdata, 0);
    chk("rst_err", err, 0);
    reset_n = 1;
    step();

    // i read and d write, cycle by cycle
    for (int k = 0; k < 13; k++) begin
      i_req = v[k].ir; i_address = v[k].ia;
      d_req = v[k].dr; d_write = v[k].dw;
      d_address = v[k].da; d_wdata = v[k].dd;
      m_accept = v[k].ma; m_valid = v[k].mv; m_rdata = v[k].md;
      #1;
      chk($sformatf("v%0d_m_req", k), m_req, v[k].xmr);
      chk($sformatf("v%0d_m_write", k), m_write, v[k].xmw);
      chk($sformatf("v%0d_m_address", k), m_address, v[k].xma);
      chk($sformatf("v%0d_m_wdata", k), m_wdata, v[k].xmd);
      chk($sformatf("v%0d_i_done", k), i_done, v[k].xid);
      chk($sformatf("v%0d_d_done", k), d_done, v[k].xdd);
      chk($sformatf("v%0d_i_rdata", k), i_rdata, v[k].xir);
      chk($sformatf("v%0d_d_rdata", k), d_rdata, v[k].xdr);
      chk($sformatf("v%0d_i_stall", k), i_stall, v[k].xis);
      chk($sformatf("v%0d_d_stall", k), d_stall, v[k].xds);
      step();
    end
    zero_in();
    step();

    // simultaneous requests: d first, i after the gap
    i_req = 1; i_address = 32'h3000;
    d_req = 1; d_write = 0; d_address = 32'h2000;
    step();
    chk("t2_mreq_d", m_req, 1);
    chk("t2_addr_d", m_address, 32'h2000);
    m_accept = 1; step(); m_accept = 0;
    m_valid = 1; m_rdata = 32'hA5A5_0001; step(); m_valid = 0;
    chk("t2_d_done", d_done, 1);
    chk("t2_d_rdata", d_rdata, 32'hA5A5_0001);
    chk("t2_i_wait", i_done, 0);
    d_req = 0;
    step();
    chk("t2_gap", m_req, 0);
    step();
    chk("t2_mreq_i", m_req, 1);
    chk("t2_addr_i", m_address, 32'h3000);
    chk("t2_write_i", m_write, 0);
    m_accept = 1; step(); m_accept = 0;
    m_valid = 1; m_rdata = 32'hA5A5_0002; step(); m_valid = 0;
    chk("t2_i_done", i_done, 1);
    chk("t2_i_rdata", i_rdata, 32'hA5A5_0002);
    i_req = 0;
    step();

    // randomized traffic against the memory model
    mon = 1;
    fork
      begin
        fork
          i_thread();
          d_thread();
        join
        rstop = 1;
      end
      responder();
    join
    mon = 0;
    zero_in();
    step();
    chk("rand_err", err, 0);

    // WAIT timeout
    rd_txn(1, 32'h80, 32'h1357_9BDF, "t4_pre");
    d_req = 1; d_write = 0; d_address = 32'h70;
    wait_mreq("t4_mreq");
    m_accept = 1; step(); m_accept = 0;
    n = 0;
    e_prev = err;
    while (!d_done && n < 100) begin
      e_prev = err;
      step();
      n++;
    end
    chk("t4_done", d_done, 1);
    chk("t4_wait_cycles", n, TO);
    chk("t4_rdata", d_rdata, 0);
    chk("t4_err", err, 1);
    chk("t4_err_before", e_prev, 0);
    d_req = 0;
    m_valid = 1; m_rdata = 32'hBAD0_BAD0; step(); m_valid = 0;
    repeat (3) step();
    chk("t4_err_sticky", err, 1);
    chk("t4_late_valid", d_rdata, 0);
    chk("t4_idle", m_req, 0);

    // reset during WAIT
    i_req = 1; i_address = 32'h90;
    wait_mreq("t5_mreq");
    m_accept = 1; step(); m_accept = 0;
    step();
    reset_n = 0;
    #1;
    chk("t5_m_req", m_req, 0);
    chk("t5_i_done", i_done, 0);
    chk("t5_err", err, 0);
    i_req = 0;
    step();
    reset_n = 1;
    m_valid = 1; m_rdata = 32'h1111; step(); m_valid = 0;
    step();
    chk("t5_idle", m_req, 0);
    chk("t5_no_done", i_done, 0);
    rd_txn(0, 32'hA0, 32'h2468_ACE0, "t5_rec");

    // reset during ISSUE drops m_req at once
    i_req = 1; i_address = 32'hB0;
    wait_mreq("t5b_mreq");
    reset_n = 0;
    #1;
    chk("t5b_m_req", m_req, 0);
    i_req = 0;
    step();
    reset_n = 1;
    step();
    chk("t5b_idle", m_req, 0);

    // d held constantly with i waiting
    i_req = 1; i_address = 32'h60;
    d_req = 1; d_write = 1; d_address = 32'h50; d_wdata = 32'h1;
    m_accept = 1; m_valid = 1; m_rdata = 32'h1234;
    dcnt = 0;
    igr = 0;
    for (int c = 0; c < 60; c++) begin
      step();
      if (m_req) begin
        if (m_address == 32'h60) igr++;
        else if (igr == 0) dcnt++;
      end
    end
`ifdef MEMORY_ARBITER_FAIRNESS_EN
    chk("t6_d_streak", dcnt, 4);
    chk("t6_i_granted", igr > 0, 1);
`else
    chk("t6_i_starved", igr, 0);
    chk("t6_d_many", dcnt >= 15, 1);
    chk("t6_i_stall", i_stall, 1);
`endif
    zero_in();
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
